div_reconstruct: RTL

Sequential reconstructor for the repeated-subtraction divider: given divisor, quotient and remainder, it rebuilds the dividend as `quot*divisor + rem` by repeated addition. It is a small FSM-controlled datapath: load registers, an accumulator with add-enable, a down-counter with decrement, and a zero-detect status. It sits beside the divider as its inverse, so results can be round-trip checked in system and on the bench. It also flags malformed inputs: a zero divisor, or a remainder that is not less than the divisor.

---
 rtl/div_reconstruct.sv | 110 +++++++++++
 1 files changed

// File: rtl/div_reconstruct.sv
// div_reconstruct
//   Inverse of the repeated-subtraction divider. Given a divisor, quotient
//   and remainder it rebuilds the dividend as quot*divisor + rem. It starts
//   the accumulator at rem and adds the divisor quot times. It also flags
//   malformed operand sets: a zero divisor, and a remainder that is not
//   less than the divisor.
//
// Ports
//   clk      in   1    rising-edge clock
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    request, sampled only in IDLE
//   divisor  in   W    divisor operand, sampled at the LOAD edge
//   quot     in   W    quotient operand, sampled at the LOAD edge
//   rem      in   W    remainder operand, sampled at the LOAD edge
//   result   out  2W   reconstructed dividend, held until the next LOAD
//   busy     out  1    high in every state except IDLE
//   done     out  1    one-cycle pulse in DONE
//   div0     out  1    divisor was zero, held until the next LOAD
//   rem_err  out  1    rem >= divisor with a non-zero divisor, held until the next LOAD
module div_reconstruct #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   divisor,
    input  logic [W-1:0]   quot,
    input  logic [W-1:0]   rem,
    output logic [2*W-1:0] result,
    output logic           busy,
    output logic           done,
    output logic           div0,
    output logic           rem_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ADD,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   dvs;   // latched divisor
    logic [W-1:0]   cnt;   // additions still to perform
    logic [2*W-1:0] acc;   // running sum, drives result directly

    // NOTE: sequential state is written only with non-blocking assignments,
    // so every register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case statement, so paths
    // that do not assign it cannot infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_CHECK;
            // A zero divisor exits straight away: adding zero any number of
            // times leaves the sum at rem, so the loop would be wasted cycles.
            S_CHECK: state_nxt = (cnt == '0 || dvs == '0) ? S_DONE : S_ADD;
            S_ADD:   state_nxt = S_CHECK;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The sum never exceeds (2^W-1)^2 + 2^W-1, which is below 2^2W.
    // The add therefore needs no carry-out.
    // cnt cannot wrap below zero, because CHECK leaves the loop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            div0    <= 1'b0;
            rem_err <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    acc     <= {{W{1'b0}}, rem};
                    dvs     <= divisor;
                    cnt     <= quot;
                    div0    <= (divisor == '0);
                    // This flag is informational only; the sum is still formed.
                    rem_err <= (divisor != '0) && (rem >= divisor);
                end
                S_ADD: begin
                    acc <= acc + {{W{1'b0}}, dvs};
                    cnt <= cnt - W'(1);
                end
                default: ;
            endcase
        end
    end

    assign result = acc;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

endmodule
